// File: rtl/sync_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_mem_arbiter_pkg
// Description : Shared state encoding and default sizes for sync_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_mem_arbiter_pkg;

    localparam int         c_addr_w     = 5;
    localparam int         c_data_w     = 8;
    localparam logic [7:0] c_init_value = 8'h00;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter; bit 0 is requester A.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       accept,
    output logic [1:0] gnt
);

    // High when B holds priority for the next contended cycle
    logic r_prio_b;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_prio_b ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_b <= 1'b0;
        end else if (accept) begin
            r_prio_b <= gnt[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sync_mem_arbiter
// Description : Clears a single-port sync memory, then shares it between two
//               requesters with round-robin grants and 1-cycle read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_mem_arbiter
    import sync_mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W     = c_addr_w,
    parameter int                DATA_W     = c_data_w,
    parameter logic [DATA_W-1:0] INIT_VALUE = c_init_value
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    output logic              init_done,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int                c_depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(c_depth - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_a_rsp;
    logic              r_b_rsp;
    logic              w_arb_en;
    logic              w_accept;
    logic [1:0]        w_gnt;
    logic              w_wen;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_raddr;

    // A clear request wins over any pending request in the same cycle
    assign w_arb_en = (r_state == ST_RUN) && !init_start;
    assign w_accept = (a_valid && w_gnt[0]) || (b_valid && w_gnt[1]);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({b_valid, a_valid}),
        .en     (w_arb_en),
        .accept (w_accept),
        .gnt    (w_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_a_rsp <= 1'b0;
            r_b_rsp <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a_rsp <= w_gnt[0] && !a_we;
            r_b_rsp <= w_gnt[1] && !b_we;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wen       = 1'b0;
        w_waddr     = '0;
        w_wdata     = '0;
        w_raddr     = '0;
        case (r_state)
            ST_INIT: begin
                w_wen     = 1'b1;
                w_waddr   = r_cnt;
                w_wdata   = INIT_VALUE;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (init_start) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end else if (w_gnt[0]) begin
                    if (a_we) begin
                        w_wen   = 1'b1;
                        w_waddr = a_addr;
                        w_wdata = a_wdata;
                    end else begin
                        w_raddr = a_addr;
                    end
                end else if (w_gnt[1]) begin
                    if (b_we) begin
                        w_wen   = 1'b1;
                        w_waddr = b_addr;
                        w_wdata = b_wdata;
                    end else begin
                        w_raddr = b_addr;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Reset holds the memory port quiet even though the FSM sits in ST_INIT
    assign mem_write_en      = w_wen && !rst;
    assign mem_write_address = rst ? '0 : w_waddr;
    assign mem_write_data    = rst ? '0 : w_wdata;
    assign mem_read_address  = rst ? '0 : w_raddr;

    assign init_done   = (r_state == ST_RUN);
    assign a_ready     = w_gnt[0];
    assign b_ready     = w_gnt[1];
    assign a_rsp_valid = r_a_rsp;
    assign b_rsp_valid = r_b_rsp;
    assign rsp_data    = mem_read_data;

endmodule
`default_nettype wire

// File: tb/tb_sync_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_mem_arbiter
// Description : Directed self-checking bench with a behavioural 32x8 memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_start = 1'b0;
    logic       init_done;
    logic       a_valid = 1'b0, a_we = 1'b0, a_ready, a_rsp_valid;
    logic       b_valid = 1'b0, b_we = 1'b0, b_ready, b_rsp_valid;
    logic [4:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic [7:0] rsp_data;
    logic [4:0] mem_read_address, mem_write_address;
    logic       mem_write_en;
    logic [7:0] mem_write_data, mem_read_data;

    logic [7:0] mem [32];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sync_mem_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .init_start        (init_start),
        .init_done         (init_done),
        .a_valid           (a_valid),
        .a_ready           (a_ready),
        .a_we              (a_we),
        .a_addr            (a_addr),
        .a_wdata           (a_wdata),
        .a_rsp_valid       (a_rsp_valid),
        .b_valid           (b_valid),
        .b_ready           (b_ready),
        .b_we              (b_we),
        .b_addr            (b_addr),
        .b_wdata           (b_wdata),
        .b_rsp_valid       (b_rsp_valid),
        .rsp_data          (rsp_data),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_write_en      (mem_write_en),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data)
    );

    // Behavioural memory: read-first, registered read data, garbage at start
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    end

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_address] <= mem_write_data;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) mem_read_data <= 8'h00;
        else     mem_read_data <= mem[mem_read_address];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_clear(input bit in_place);
        for (int k = 0; k < 32; k++) begin
            if (!(in_place && k == 0)) begin
                step();
                init_start = 1'b0;
            end
            #1;
            n_checks++; if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL clr_we k=%0d: got %b want 1", k, mem_write_en); end
            n_checks++; if (mem_write_address !== 5'(k)) begin n_fail++; $display("FAIL clr_addr k=%0d: got %0d want %0d", k, mem_write_address, k); end
            n_checks++; if (mem_write_data !== 8'h00) begin n_fail++; $display("FAIL clr_data k=%0d: got %h want 00", k, mem_write_data); end
            n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL clr_done k=%0d: got %b want 0", k, init_done); end
            n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL clr_ready k=%0d: got %b want 00", k, {a_ready, b_ready}); end
            n_checks++; if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL clr_rsp k=%0d: got %b want 00", k, {a_rsp_valid, b_rsp_valid}); end
        end
        step();
        #1;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL clr_end_done: got %b want 1", init_done); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (3) step();
        #1;
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", init_done); end
        n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {a_ready, b_ready}); end
        n_checks++; if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp: got %b want 00", {a_rsp_valid, b_rsp_valid}); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", mem_write_en); end
        n_checks++; if ({mem_write_address, mem_read_address, mem_write_data} !== 18'h0) begin n_fail++; $display("FAIL rst_memport: got %h want 0", {mem_write_address, mem_read_address, mem_write_data}); end
        n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rspdata: got %h want 00", rsp_data); end
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b0;
        check_clear(1'b1);
    endtask

    task automatic test_read_all;
        for (int i = 0; i < 32; i++) begin
            step();
            a_valid = 1'b1; a_we = 1'b0; a_addr = 5'(i);
            #1;
            n_checks++; if (a_ready !== 1'b1 || mem_read_address !== 5'(i) || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rdall_req i=%0d: got rdy=%b ra=%0d we=%b want 1/%0d/0", i, a_ready, mem_read_address, mem_write_en, i); end
            if (i > 0) begin
                n_checks++; if (a_rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL rdall_rsp i=%0d: got v=%b d=%h want 1/00", i, a_rsp_valid, rsp_data); end
            end
        end
        step();
        a_valid = 1'b0;
        #1;
        n_checks++; if (a_rsp_valid !== 1'b1 || rsp_data !== 8'h00 || b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rdall_last: got a=%b b=%b d=%h want 1/0/00", a_rsp_valid, b_rsp_valid, rsp_data); end
    endtask

    task automatic test_write_then_read;
        step();
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd7; a_wdata = 8'h5A;
        #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready: got a=%b b=%b want 1/0", a_ready, b_ready); end
        n_checks++; if (mem_write_en !== 1'b1 || mem_write_address !== 5'd7 || mem_write_data !== 8'h5A) begin n_fail++; $display("FAIL wr_port: got we=%b wa=%0d wd=%h want 1/7/5a", mem_write_en, mem_write_address, mem_write_data); end
        step();
        a_valid = 1'b0; a_we = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd7;
        #1;
        n_checks++; if (b_ready !== 1'b1 || mem_read_address !== 5'd7) begin n_fail++; $display("FAIL wtr_rdreq: got rdy=%b ra=%0d want 1/7", b_ready, mem_read_address); end
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_norsp: got %b want 0", a_rsp_valid); end
        step();
        b_valid = 1'b0;
        #1;
        n_checks++; if (b_rsp_valid !== 1'b1 || rsp_data !== 8'h5A || a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wtr_rsp: got b=%b a=%b d=%h want 1/0/5a", b_rsp_valid, a_rsp_valid, rsp_data); end
        step();
        #1;
        n_checks++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wtr_once: got %b want 0", b_rsp_valid); end
    endtask

    task automatic test_contention;
        bit exp_a;
        step();
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd1; a_wdata = 8'h11;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd2; b_wdata = 8'h22;
        #1;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL pre_b: got %b want 1", b_ready); end
        for (int i = 0; i < 8; i++) begin
            step();
            a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd1;
            b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd2;
            #1;
            exp_a = (i % 2 == 0);
            n_checks++; if (a_ready !== exp_a || b_ready !== !exp_a) begin n_fail++; $display("FAIL rr_gnt i=%0d: got a=%b b=%b want a=%b", i, a_ready, b_ready, exp_a); end
            n_checks++; if (mem_read_address !== (exp_a ? 5'd1 : 5'd2)) begin n_fail++; $display("FAIL rr_addr i=%0d: got %0d", i, mem_read_address); end
            if (i > 0) begin
                n_checks++; if (a_rsp_valid !== !exp_a || b_rsp_valid !== exp_a || rsp_data !== (exp_a ? 8'h22 : 8'h11)) begin n_fail++; $display("FAIL rr_rsp i=%0d: got a=%b b=%b d=%h", i, a_rsp_valid, b_rsp_valid, rsp_data); end
            end
        end
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        n_checks++; if (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0 || rsp_data !== 8'h22) begin n_fail++; $display("FAIL rr_last: got a=%b b=%b d=%h want 0/1/22", a_rsp_valid, b_rsp_valid, rsp_data); end
    endtask

    task automatic test_init_start;
        step();
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd31; a_wdata = 8'hFF;
        #1;
        n_checks++; if (a_ready !== 1'b1 || mem_write_en !== 1'b1) begin n_fail++; $display("FAIL is_wr: got rdy=%b we=%b want 1/1", a_ready, mem_write_en); end
        step();
        a_we = 1'b0;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd31;
        init_start = 1'b1;
        #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b00 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL is_nogrant: got rdy=%b we=%b want 00/0", {a_ready, b_ready}, mem_write_en); end
        n_checks++; if (a_rsp_valid !== 1'b1 || rsp_data !== 8'hFF) begin n_fail++; $display("FAIL is_rspkept: got v=%b d=%h want 1/ff", a_rsp_valid, rsp_data); end
        check_clear(1'b0);
        n_checks++; if (b_ready !== 1'b1 || mem_read_address !== 5'd31) begin n_fail++; $display("FAIL is_bserved: got rdy=%b ra=%0d want 1/31", b_ready, mem_read_address); end
        step();
        b_valid = 1'b0;
        #1;
        n_checks++; if (b_rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL is_cleared: got v=%b d=%h want 1/00", b_rsp_valid, rsp_data); end
    endtask

    task automatic test_reset_mid;
        step();
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd5;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", a_ready); end
        step();
        a_valid = 1'b0;
        #1;
        n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rm_rsp_pre: got %b want 1", a_rsp_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (a_rsp_valid !== 1'b0 || init_done !== 1'b0 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rm_rsp_drop: got v=%b done=%b we=%b want 0/0/0", a_rsp_valid, init_done, mem_write_en); end
        step();
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 10; k++) begin
            step();
            #1;
        end
        n_checks++; if (mem_write_address !== 5'd10 || mem_write_en !== 1'b1) begin n_fail++; $display("FAIL rm_cnt10: got wa=%0d we=%b want 10/1", mem_write_address, mem_write_en); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_write_en !== 1'b0 || mem_write_address !== 5'd0) begin n_fail++; $display("FAIL rm_midclr: got we=%b wa=%0d want 0/0", mem_write_en, mem_write_address); end
        step();
        rst = 1'b0;
        check_clear(1'b1);
    endtask

    task automatic test_rr_b_only;
        for (int i = 0; i < 3; i++) begin
            step();
            b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd3;
            #1;
            n_checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL bonly i=%0d: got a=%b b=%b want 0/1", i, a_ready, b_ready); end
        end
        step();
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd4;
        #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL bonly_afirst: got a=%b b=%b want 1/0", a_ready, b_ready); end
        n_checks++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bonly_rsp: got %b want 1", b_rsp_valid); end
        step();
        a_valid = 1'b0;
        #1;
        n_checks++; if (b_ready !== 1'b1 || a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bonly_bnext: got rdy=%b arsp=%b want 1/1", b_ready, a_rsp_valid); end
        step();
        b_valid = 1'b0;
        #1;
        n_checks++; if (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bonly_brsp: got b=%b a=%b want 1/0", b_rsp_valid, a_rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_write_then_read();
        test_contention();
        test_init_start();
        test_reset_mid();
        test_rr_b_only();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_mem_arbiter.md
# sync_mem_arbiter

Two-requester round-robin controller for a single-port 32×8 synchronous memory (registered read data, one-cycle read latency, no array reset). It owns the memory's address, write and data inputs. After every reset, and on request, it clears the array to a known value. It then shares the memory between requester A and requester B through valid/ready request channels and fixed-latency read responses.

## Interface
Parameters:
- ADDR_W, 5, address width; memory depth DEPTH = 2**ADDR_W
- DATA_W, 8, data width
- INIT_VALUE, 0, word written to every location during clear

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- init_start  in  1  single-cycle pulse that requests a full array clear
- init_done  out  1  high when the array is cleared and requests are served
- a_valid / b_valid  in  1  request present
- a_ready / b_ready  out  1  request accepted this cycle
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  request address
- a_wdata / b_wdata  in  DATA_W  write data
- a_rsp_valid / b_rsp_valid  out  1  read data valid for that requester
- rsp_data  out  DATA_W  read data, shared by both requesters
- mem_read_address  out  ADDR_W  to the memory
- mem_write_address  out  ADDR_W  to the memory
- mem_write_en  out  1  to the memory
- mem_write_data  out  DATA_W  to the memory
- mem_read_data  in  DATA_W  from the memory; registered, valid one cycle after the address is presented

## Operation
- FSM states: ST_INIT and ST_RUN. The reset state is ST_INIT with clear counter cnt = 0.
- ST_INIT:
  - Drives mem_write_en=1, mem_write_address=cnt, mem_write_data=INIT_VALUE.
  - cnt increments every cycle.
  - When cnt = DEPTH-1, the next state is ST_RUN. cnt wraps to 0.
  - a_ready=b_ready=0. init_done=0. init_start is ignored.
- ST_RUN:
  - init_done=1.
  - Exactly one request may be granted per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that did not win the most recent grant is granted. The priority pointer resets to favour A.
  - The pointer updates only on an accepted transfer.
  - x_ready equals the grant combinationally. A transfer occurs when x_valid && x_ready.
  - A requester must hold its valid, we, addr and wdata stable until accepted.
- Granted write: mem_write_en=1, mem_write_address/mem_write_data come from the winner. No response is generated.
- Granted read: mem_read_address = winner addr, mem_write_en=0. x_rsp_valid pulses exactly once, in the next cycle. rsp_data = mem_read_data in that cycle.
- No grant: mem_write_en=0, mem_read_address=0.
- Responses have no backpressure. The requester must sample rsp_data while x_rsp_valid is high.
- init_start in ST_RUN:
  - Takes priority over requests in that cycle: no grant, both ready=0.
  - The next state is ST_INIT with cnt=0.
  - A read response due from the previous cycle is still delivered.
- Reset mid-operation:
  - The FSM returns to ST_INIT with cnt=0.
  - Pending responses are dropped.
  - The clear restarts from address 0.

## Timing
- Reset values: init_done=0, a_ready=b_ready=0, a_rsp_valid=b_rsp_valid=0.
- All mem_* outputs are forced to 0 while rst is high. rsp_data follows mem_read_data, which is 0 in reset.
- The clear takes DEPTH cycles (32 by default), in the first DEPTH cycles after rst falls or after the init_start cycle.
- init_done rises in cycle DEPTH after rst falls, and the first grant is possible in that same cycle.
- Read latency: request accepted in cycle N, response in cycle N+1.
- Back-to-back reads from alternating requesters give one response per cycle.
- Write accepted in cycle N, then a read of the same address accepted in cycle N+1 returns the new data.
- Under continuous contention, grants alternate A, B, A, B… Maximum wait is 1 cycle.

## Structure
- Package sync_mem_arbiter_pkg holds:
  - the state enum {ST_INIT, ST_RUN};
  - default ADDR_W, DATA_W and INIT_VALUE localparams.
- Sub-module rr_arbiter2 is a 2-way round-robin arbiter containing the priority pointer.
  - Inputs: req[1:0], an enable, and an accept qualifier for the pointer update.
  - Output: one-hot gnt.
- The top level holds the FSM, cnt, the memory-side muxing, and the response flops.

## Test plan
- Release reset, idle: mem_write_en=1 with addresses 0..31 over 32 cycles, data 0x00; init_done=1 in cycle 32; then A reads every address and gets 0x00.
- A writes 0x5A to addr 7 in cycle N, B reads addr 7 in cycle N+1: b_rsp_valid in N+2 with rsp_data=0x5A; a_rsp_valid stays 0.
- Both requesters reading continuously for 8 cycles (A addr 1, B addr 2, preloaded 0x11/0x22): grants A,B,A,B…; responses alternate 0x11/0x22, one per cycle.
- Write 0xFF to addr 31, pulse init_start together with a pending B request: no grant that cycle, 32 clear cycles with ready low, then a read of addr 31 returns 0x00 and B is served.
- Assert rst during a read's response cycle and mid-clear at cnt=10: rsp_valid goes to 0 immediately; after release the clear restarts at address 0 and takes 32 full cycles.
- Only B valid for 3 cycles, then both valid: B granted 3 times, then A first.
